// File: rtl/dbus_load_unit.sv
// Load-side DBUS master: one outstanding read, lane-aligned and sign/zero-extended into rdo.
// Optional feature macro: LOAD_MISALIGN_TRAP_EN (trap misaligned loads instead of issuing them).
module dbus_load_unit #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  output logic              dbus_req_valid,
  output logic [ADDR_W-1:0] dbus_req_addr,
  output logic [2:0]        dbus_req_size,
  input  logic              dbus_resp_addr_ok,
  input  logic              dbus_resp_data_ok,
  input  logic [DATA_W-1:0] dbus_resp_data,
  output logic              rdo_valid,
  output logic [DATA_W-1:0] rdo,
  output logic              ld_misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              misalign;
  logic              accept;
  logic              take_data;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] ext;

`ifdef LOAD_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    case (ld_size)
      2'd1:    misalign = ld_addr[0];
      2'd2:    misalign = |ld_addr[1:0];
      2'd3:    misalign = |ld_addr[2:0];
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    ld_ready       = 1'b0;
    dbus_req_valid = 1'b0;
    rdo_valid      = 1'b0;
    take_data      = 1'b0;
    accept         = 1'b0;
    case (state)
      S_IDLE: begin
        ld_ready = 1'b1;
        accept   = ld_valid;
        if (ld_valid && !misalign) state_nx = S_REQ;
      end
      S_REQ: begin
        dbus_req_valid = 1'b1;
        // data_ok without addr_ok is not a response to this request
        if (dbus_resp_addr_ok) begin
          take_data = dbus_resp_data_ok;
          state_nx  = dbus_resp_data_ok ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (dbus_resp_data_ok) begin
          take_data = 1'b1;
          state_nx  = S_DONE;
        end
      end
      S_DONE: begin
        rdo_valid = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Zero-filling shift: bytes beyond bit 63 read as zero before extension
  assign sh = dbus_resp_data >> {addr_q[2:0], 3'b000};

  always_comb begin
    ext = sh;
    case (size_q)
      2'd0:    ext = {{(DATA_W-8){~uns_q & sh[7]}},   sh[7:0]};
      2'd1:    ext = {{(DATA_W-16){~uns_q & sh[15]}}, sh[15:0]};
      2'd2:    ext = {{(DATA_W-32){~uns_q & sh[31]}}, sh[31:0]};
      default: ext = sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      size_q <= '0;
      uns_q  <= 1'b0;
      rdo    <= '0;
    end else begin
      if (accept && !misalign) begin
        addr_q <= ld_addr;
        size_q <= ld_size;
        uns_q  <= ld_unsigned;
      end
      if (take_data) rdo <= ext;
    end
  end

`ifdef LOAD_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) ld_misalign <= 1'b0;
    else       ld_misalign <= accept & misalign;
  end
`else
  assign ld_misalign = 1'b0;
`endif

  assign dbus_req_addr = addr_q;
  assign dbus_req_size = {1'b0, size_q};

endmodule

// File: tb/tb_dbus_load_unit.sv
// Directed, table-driven bench for dbus_load_unit with hand-written reset and misalign sequences.
module tb_dbus_load_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic        ld_ready;
  logic [63:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic        dbus_req_valid;
  logic [63:0] dbus_req_addr;
  logic [2:0]  dbus_req_size;
  logic        dbus_resp_addr_ok;
  logic        dbus_resp_data_ok;
  logic [63:0] dbus_resp_data;
  logic        rdo_valid;
  logic [63:0] rdo;
  logic        ld_misalign;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  dbus_load_unit #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk               (clk),
    .reset             (reset),
    .ld_valid          (ld_valid),
    .ld_ready          (ld_ready),
    .ld_addr           (ld_addr),
    .ld_size           (ld_size),
    .ld_unsigned       (ld_unsigned),
    .dbus_req_valid    (dbus_req_valid),
    .dbus_req_addr     (dbus_req_addr),
    .dbus_req_size     (dbus_req_size),
    .dbus_resp_addr_ok (dbus_resp_addr_ok),
    .dbus_resp_data_ok (dbus_resp_data_ok),
    .dbus_resp_data    (dbus_resp_data),
    .rdo_valid         (rdo_valid),
    .rdo               (rdo),
    .ld_misalign       (ld_misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] resp;
    logic [63:0] exp;
    int unsigned aok_dly;
    int unsigned dok_dly;
    logic        early;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input vec_t v, input string tag);
    int unsigned c_acc;
    check({tag, " ld_ready idle"}, 64'(ld_ready), 64'd1);
    ld_valid    = 1'b1;
    ld_addr     = v.addr;
    ld_size     = v.size;
    ld_unsigned = v.uns;
    c_acc       = cyc;
    step();
    ld_valid    = 1'b0;
    ld_addr     = 64'hFFFF_FFFF_FFFF_FFFF;
    check({tag, " req_valid"}, 64'(dbus_req_valid), 64'd1);
    check({tag, " ld_ready busy"}, 64'(ld_ready), 64'd0);
    check({tag, " req_addr"}, dbus_req_addr, v.addr);
    check({tag, " req_size"}, 64'(dbus_req_size), {62'd0, v.size});
    for (int unsigned i = 0; i < v.aok_dly; i++) begin
      dbus_resp_data_ok = v.early;
      dbus_resp_data    = ~v.resp;
      step();
      check({tag, " stall req_valid"}, 64'(dbus_req_valid), 64'd1);
      check({tag, " stall req_addr"}, dbus_req_addr, v.addr);
      check({tag, " stall req_size"}, 64'(dbus_req_size), {62'd0, v.size});
      check({tag, " stall rdo_valid"}, 64'(rdo_valid), 64'd0);
    end
    dbus_resp_addr_ok = 1'b1;
    dbus_resp_data_ok = (v.dok_dly == 0);
    dbus_resp_data    = v.resp;
    step();
    dbus_resp_addr_ok = 1'b0;
    dbus_resp_data_ok = 1'b0;
    if (v.dok_dly > 0) begin
      check({tag, " wait req_valid"}, 64'(dbus_req_valid), 64'd0);
      check({tag, " wait rdo_valid"}, 64'(rdo_valid), 64'd0);
      for (int unsigned i = 1; i < v.dok_dly; i++) begin
        step();
        check({tag, " wait rdo_valid"}, 64'(rdo_valid), 64'd0);
      end
      dbus_resp_data_ok = 1'b1;
      dbus_resp_data    = v.resp;
      step();
      dbus_resp_data_ok = 1'b0;
    end
    dbus_resp_data = 64'h5555_5555_5555_5555;
    check({tag, " rdo_valid"}, 64'(rdo_valid), 64'd1);
    check({tag, " rdo"}, rdo, v.exp);
    check({tag, " latency"}, 64'(cyc - c_acc + 1), 64'(3 + v.aok_dly + v.dok_dly));
    step();
    check({tag, " rdo_valid pulse"}, 64'(rdo_valid), 64'd0);
    check({tag, " rdo hold"}, rdo, v.exp);
    check({tag, " back to idle"}, 64'(ld_ready), 64'd1);
  endtask

  vec_t vecs [9];
  vec_t v;

  initial begin
    vecs[0] = '{64'h1003, 2'd0, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 0, 0, 1'b0};
    vecs[1] = '{64'h2004, 2'd2, 1'b1, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321, 0, 1, 1'b0};
    vecs[2] = '{64'h2004, 2'd2, 1'b0, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 4, 2, 1'b1};
    vecs[3] = '{64'h3000, 2'd3, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 1'b0};
    vecs[4] = '{64'h5006, 2'd1, 1'b1, 64'hF00D_0000_0000_0000, 64'h0000_0000_0000_F00D, 1, 0, 1'b0};
    vecs[5] = '{64'h5006, 2'd1, 1'b0, 64'hF00D_0000_0000_0000, 64'hFFFF_FFFF_FFFF_F00D, 0, 0, 1'b0};
    vecs[6] = '{64'h6007, 2'd0, 1'b1, 64'hA500_0000_0000_0000, 64'h0000_0000_0000_00A5, 0, 0, 1'b0};
    vecs[7] = '{64'h6000, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF7F, 64'h0000_0000_0000_007F, 2, 0, 1'b1};
    vecs[8] = '{64'h7008, 2'd3, 1'b1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 0, 3, 1'b0};

    reset = 1'b1;
    ld_valid = 1'b0; ld_addr = '0; ld_size = '0; ld_unsigned = 1'b0;
    dbus_resp_addr_ok = 1'b0; dbus_resp_data_ok = 1'b0; dbus_resp_data = '0;
    step();
    step();
    check("reset ld_ready", 64'(ld_ready), 64'd1);
    check("reset req_valid", 64'(dbus_req_valid), 64'd0);
    check("reset req_addr", dbus_req_addr, 64'd0);
    check("reset req_size", 64'(dbus_req_size), 64'd0);
    check("reset rdo_valid", 64'(rdo_valid), 64'd0);
    check("reset rdo", rdo, 64'd0);
    check("reset ld_misalign", 64'(ld_misalign), 64'd0);
    reset = 1'b0;
    step();

    // Consecutive calls: each new load is offered in the cycle right after rdo_valid
    for (int i = 0; i < 9; i++) run_load(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting for data abandons the load
    ld_valid = 1'b1; ld_addr = 64'h8000; ld_size = 2'd3; ld_unsigned = 1'b0;
    step();
    ld_valid = 1'b0;
    dbus_resp_addr_ok = 1'b1;
    step();
    dbus_resp_addr_ok = 1'b0;
    check("wait state req_valid", 64'(dbus_req_valid), 64'd0);
    check("wait state ld_ready", 64'(ld_ready), 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst mid ld_ready", 64'(ld_ready), 64'd1);
    check("rst mid rdo_valid", 64'(rdo_valid), 64'd0);
    check("rst mid rdo", rdo, 64'd0);
    dbus_resp_data_ok = 1'b1;
    dbus_resp_data = 64'h1234_5678_9ABC_DEF0;
    step();
    dbus_resp_data_ok = 1'b0;
    check("stray data_ok rdo_valid", 64'(rdo_valid), 64'd0);
    step();
    check("stray data_ok rdo_valid+1", 64'(rdo_valid), 64'd0);
    check("stray data_ok rdo", rdo, 64'd0);
    check("stray data_ok ld_ready", 64'(ld_ready), 64'd1);

    run_load(vecs[3], "post-reset");

`ifdef LOAD_MISALIGN_TRAP_EN
    ld_valid = 1'b1; ld_addr = 64'h4001; ld_size = 2'd1; ld_unsigned = 1'b0;
    step();
    ld_valid = 1'b0;
    check("misalign strobe", 64'(ld_misalign), 64'd1);
    check("misalign req_valid", 64'(dbus_req_valid), 64'd0);
    check("misalign ld_ready", 64'(ld_ready), 64'd1);
    check("misalign rdo", rdo, vecs[3].exp);
    check("misalign rdo_valid", 64'(rdo_valid), 64'd0);
    step();
    check("misalign strobe end", 64'(ld_misalign), 64'd0);
    check("misalign req_valid+1", 64'(dbus_req_valid), 64'd0);
    check("misalign req_addr kept", dbus_req_addr, vecs[3].addr);
    run_load(vecs[0], "after misalign");
`else
    v = '{64'h4001, 2'd1, 1'b0, 64'h0000_0000_00AB_CD00, 64'hFFFF_FFFF_FFFF_ABCD, 0, 0, 1'b0};
    run_load(v, "misaligned LH");
    check("misaligned LH no trap", 64'(ld_misalign), 64'd0);
    v = '{64'h4006, 2'd2, 1'b0, 64'h8234_5678_9ABC_DEF0, 64'h0000_0000_0000_8234, 0, 0, 1'b0};
    run_load(v, "LW past bit63");
    v = '{64'h4007, 2'd3, 1'b0, 64'hFF00_0000_0000_0000, 64'h0000_0000_0000_00FF, 0, 0, 1'b0};
    run_load(v, "LD past bit63");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
